// File: rtl/des_sbox_hash_engine.sv
// Byte-serial hash built on the DES S5 box: absorbs a length-prefixed byte stream,
// then the length itself, and publishes a 32-bit digest with a one-cycle pulse.
module des_sbox_hash_engine #(
  parameter int ROUNDS = 1,
  parameter int LEN_W  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [7:0]       msg_byte,
  output logic             busy,
  output logic             hash_ready,
  output logic [31:0]      digest
);
  localparam int NB = LEN_W / 8;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NB - 1);
  localparam logic [31:0]   IV       = 32'h4B71DF03;

  typedef enum logic [1:0] {IDLE, ABSORB, FINAL, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [31:0]      h;
  logic [RW-1:0]    rnd;
  logic [KW-1:0]    k;
  logic [5:0]       idx_r;
  logic [7:0]       len_byte;

  function automatic logic [5:0] m6(input logic [7:0] b);
    return {b[3] ^ b[2], b[1], b[0], b[7], b[6], b[5] ^ b[4]};
  endfunction

  function automatic logic [3:0] sbox(input logic [5:0] x);
    logic [63:0] row;
    case ({x[5], x[0]})
      2'd0:    row = 64'h2C417AB6853FD0E9;
      2'd1:    row = 64'hEB2C47D150FA3986;
      2'd2:    row = 64'h421BAD78F9C5630E;
      default: row = 64'hB8C71E2D6F09A453;
    endcase
    return row[(15 - int'(x[4:1])) * 4 +: 4];
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] n, input logic [1:0] r);
    case (r)
      2'd0:    return n;
      2'd1:    return {n[2:0], n[3]};
      2'd2:    return {n[1:0], n[3:2]};
      default: return {n[0], n[3:1]};
    endcase
  endfunction

  // Nibble i sits at bits [31-4i -: 4], so H[0] is the most significant nibble.
  function automatic logic [31:0] round_f(input logic [31:0] hin, input logic [5:0] idx);
    logic [3:0]  s;
    logic [31:0] hout;
    s    = sbox(idx);
    hout = '0;
    for (int i = 0; i < 8; i++) begin
      hout[31 - 4 * i -: 4] = rotl4(hin[31 - 4 * ((i + 1) % 8) -: 4] ^ s, 2'(i >> 1));
    end
    return hout;
  endfunction

  assign len_byte  = 8'(len_q >> {k, 3'b000});
  assign msg_ready = (state == ABSORB) && (rnd == '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      h          <= IV;
      rnd        <= '0;
      k          <= '0;
      idx_r      <= '0;
      hash_ready <= 1'b0;
      digest     <= '0;
    end else begin
      hash_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= msg_len;
            cnt   <= msg_len;
            h     <= IV;
            rnd   <= '0;
            k     <= '0;
            state <= (msg_len != '0) ? ABSORB : FINAL;
          end
        end
        ABSORB: begin
          if (rnd != '0) begin
            h   <= round_f(h, idx_r);
            rnd <= rnd - RW'(1);
            if (rnd == RW'(1) && cnt == '0) state <= FINAL;
          end else if (msg_valid) begin
            h     <= round_f(h, m6(msg_byte));
            idx_r <= m6(msg_byte);
            cnt   <= cnt - LEN_W'(1);
            rnd   <= RND_LAST;
            // With a single round the last accept is also the last round.
            if (ROUNDS == 1 && cnt == LEN_W'(1)) state <= FINAL;
          end
        end
        FINAL: begin
          h <= round_f(h, m6(len_byte));
          if (rnd == RND_LAST) begin
            rnd <= '0;
            if (k == K_LAST) state <= DONE;
            else k <= k + KW'(1);
          end else begin
            rnd <= rnd + RW'(1);
          end
        end
        DONE: begin
          digest     <= h;
          hash_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_sbox_hash_engine.sv
// Bench for des_sbox_hash_engine: instance a (ROUNDS=1, LEN_W=8) and b (ROUNDS=3, LEN_W=64),
// digests checked by a queue-based monitor against a nibble-level reference model.
module tb_des_sbox_hash_engine;
  localparam int RB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_start, a_valid, a_ready, a_busy, a_hr;
  logic [7:0]  a_len, a_byte;
  logic [31:0] a_dig;
  logic        b_start, b_valid, b_ready, b_busy, b_hr;
  logic [63:0] b_len;
  logic [7:0]  b_byte;
  logic [31:0] b_dig;

  des_sbox_hash_engine #(.ROUNDS(1), .LEN_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .msg_len(a_len), .msg_valid(a_valid),
    .msg_ready(a_ready), .msg_byte(a_byte), .busy(a_busy), .hash_ready(a_hr), .digest(a_dig)
  );

  des_sbox_hash_engine #(.ROUNDS(RB), .LEN_W(64)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .msg_len(b_len), .msg_valid(b_valid),
    .msg_ready(b_ready), .msg_byte(b_byte), .busy(b_busy), .hash_ready(b_hr), .digest(b_dig)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [7:0]  msg_bytes[16];
  logic [3:0]  s5[4][16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] rot(input logic [3:0] n, input int r);
    logic [7:0] w;
    w = {n, n} << r;
    return w[7:4];
  endfunction

  function automatic logic [31:0] model(input int len, input int rounds, input int nlen);
    logic [3:0]  hn[8];
    logic [3:0]  t[8];
    logic [31:0] iv;
    logic [63:0] lv;
    logic [7:0]  b;
    logic [5:0]  x;
    logic [3:0]  s;
    logic [31:0] res;
    iv = 32'h4B71DF03;
    for (int i = 0; i < 8; i++) hn[i] = iv[31 - 4 * i -: 4];
    lv = 64'(len);
    for (int n = 0; n < len + nlen; n++) begin
      b = (n < len) ? msg_bytes[n] : lv[8 * (n - len) +: 8];
      x = {b[3] ^ b[2], b[1], b[0], b[7], b[6], b[5] ^ b[4]};
      s = s5[{x[5], x[0]}][x[4:1]];
      for (int r = 0; r < rounds; r++) begin
        for (int i = 0; i < 8; i++) t[i] = rot(hn[(i + 1) % 8] ^ s, i / 2);
        hn = t;
      end
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[31 - 4 * i -: 4] = hn[i];
    return res;
  endfunction

  // Monitor: every hash_ready pulse must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (a_hr === 1'b1) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_pulse: got digest %h, required no pulse", a_dig);
      end else chk("a_digest", a_dig, exp_a.pop_front());
    end
    if (b_hr === 1'b1) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_pulse: got digest %h, required no pulse", b_dig);
      end else chk("b_digest", b_dig, exp_b.pop_front());
    end
  end

  task automatic chk_reset_a();
    chk("a_rst_digest", a_dig, 0);
    chk("a_rst_hash_ready", a_hr, 0);
    chk("a_rst_msg_ready", a_ready, 0);
    chk("a_rst_busy", a_busy, 0);
  endtask

  task automatic chk_reset_b();
    chk("b_rst_digest", b_dig, 0);
    chk("b_rst_hash_ready", b_hr, 0);
    chk("b_rst_msg_ready", b_ready, 0);
    chk("b_rst_busy", b_busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Zero-length hash on instance a; called at a negedge, returns edges to hash_ready.
  task automatic run_a_zero(output int lat);
    int edges;
    edges = 0;
    exp_a.push_back(32'h956F7883);
    a_start = 1'b1;
    a_len   = 8'h00;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
    chk("a_busy_running", a_busy, 1);
    while (a_hr !== 1'b1 && edges < 100) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    lat = edges;
    chk("a_busy_at_pulse", a_busy, 0);
    @(negedge clk);
    chk("a_pulse_width", a_hr, 0);
  endtask

  // Hash of msg_bytes[0..len-1] on instance b with msg_valid high whenever a byte
  // is pending, except a gap of gap_len ready cycles before byte gap_at.
  task automatic run_b(input int len, input int gap_at, input int gap_len,
                       input bit chk_rdy, output int lat);
    int sent, gap, phase, edges;
    bit acc;
    sent = 0; gap = 0; phase = 0; edges = 0;
    exp_b.push_back(model(len, RB, 8));
    b_start = 1'b1;
    b_len   = 64'(len);
    @(posedge clk);
    @(negedge clk);
    b_start = 1'b0;
    while (b_hr !== 1'b1 && edges < 3000) begin
      if (sent < len) begin
        if (chk_rdy) chk("b_msg_ready_pattern", b_ready, phase == 0);
        if (sent == gap_at && gap < gap_len && b_ready) begin
          b_valid = 1'b0;
          gap++;
        end else begin
          b_valid = 1'b1;
          b_byte  = b_ready ? msg_bytes[sent] : 8'hFF;
        end
      end else begin
        b_valid = 1'b0;
      end
      acc = b_valid && b_ready;
      @(posedge clk); edges++;
      if (acc) begin
        sent++;
        phase = RB - 1;
      end else if (phase > 0) begin
        phase--;
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    lat = edges;
    chk("b_busy_at_pulse", b_busy, 0);
    @(negedge clk);
    chk("b_pulse_width", b_hr, 0);
  endtask

  initial begin
    int lat, lat0, lat1, edges, sent;
    bit acc;
    s5[0] = '{4'h2, 4'hC, 4'h4, 4'h1, 4'h7, 4'hA, 4'hB, 4'h6, 4'h8, 4'h5, 4'h3, 4'hF, 4'hD, 4'h0, 4'hE, 4'h9};
    s5[1] = '{4'hE, 4'hB, 4'h2, 4'hC, 4'h4, 4'h7, 4'hD, 4'h1, 4'h5, 4'h0, 4'hF, 4'hA, 4'h3, 4'h9, 4'h8, 4'h6};
    s5[2] = '{4'h4, 4'h2, 4'h1, 4'hB, 4'hA, 4'hD, 4'h7, 4'h8, 4'hF, 4'h9, 4'hC, 4'h5, 4'h6, 4'h3, 4'h0, 4'hE};
    s5[3] = '{4'hB, 4'h8, 4'hC, 4'h7, 4'h1, 4'hE, 4'h2, 4'hD, 4'h6, 4'hF, 4'h0, 4'h9, 4'hA, 4'h4, 4'h5, 4'h3};
    for (int i = 0; i < 16; i++) msg_bytes[i] = 8'(8'h3D * i + 8'h11);
    rst_n = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_len = '0; a_byte = '0;
    b_start = 1'b0; b_valid = 1'b0; b_len = '0; b_byte = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_a();
    chk_reset_b();

    // Zero-length hash: one final round on length byte 0x00.
    run_a_zero(lat);
    chk("a_zero_latency", lat, 2);

    // Reset clears a previously published digest; next hash starts from IV.
    pulse_reset();
    chk_reset_a();
    run_a_zero(lat);
    chk("a_zero_latency_after_reset", lat, 2);

    // Back-to-back: start held high; second hash (1 byte) starts on the pulse cycle.
    msg_bytes[0] = 8'h5A;
    exp_a.push_back(32'h956F7883);
    exp_a.push_back(model(1, 1, 1));
    a_start = 1'b1;
    a_len   = 8'h00;
    @(posedge clk);
    @(negedge clk);
    a_len = 8'h01; a_valid = 1'b1; a_byte = 8'h5A;
    edges = 0;
    while (a_hr !== 1'b1 && edges < 100) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    chk("a_b2b_first_latency", edges, 2);
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (a_hr !== 1'b1) chk("a_b2b_digest_hold", a_dig, 32'h956F7883);
    end while (a_hr !== 1'b1 && edges < 100);
    a_start = 1'b0; a_valid = 1'b0;
    chk("a_b2b_pulse_gap", edges, 4);
    @(negedge clk);

    // Backpressure on b: msg_valid constant, bytes offered while not ready are 0xFF.
    for (int i = 0; i < 16; i++) msg_bytes[i] = 8'(8'h3D * i + 8'h11);
    run_b(4, -1, 0, 1'b1, lat);
    chk("b_l4_latency", lat, RB * (4 + 8) + 1);

    // Stall: same 3-byte message with and without a 10-cycle gap.
    run_b(3, -1, 0, 1'b0, lat0);
    chk("b_l3_latency", lat0, RB * (3 + 8) + 1);
    run_b(3, 1, 10, 1'b0, lat1);
    chk("b_l3_stall_latency", lat1, RB * (3 + 8) + 1 + 10);

    // Reset mid-ABSORB after 2 of 5 bytes; the aborted run must not pulse.
    b_start = 1'b1;
    b_len   = 64'd5;
    @(posedge clk);
    @(negedge clk);
    b_start = 1'b0;
    sent = 0; edges = 0;
    while (sent < 2 && edges < 50) begin
      b_valid = 1'b1;
      b_byte  = msg_bytes[sent];
      acc = b_ready;
      @(posedge clk); edges++;
      if (acc) sent++;
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("b_busy_mid_absorb", b_busy, 1);
    pulse_reset();
    chk_reset_b();
    repeat (5) @(negedge clk);
    chk("b_no_pulse_after_abort", b_hr, 0);
    run_b(0, -1, 0, 1'b0, lat);
    chk("b_zero_latency", lat, RB * 8 + 1);

    repeat (3) @(negedge clk);
    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
